// File: rtl/ace_snoop_cd_responder.sv
`timescale 1ns/1ps
// ACE snoop responder: one AC snoop at a time -> dcache lookup -> CR response -> CD line beats -> state update.
// Optional perf counters (hit/miss/CD beats) are built when ACE_SNOOP_PERF_CNT_EN is defined.
module ace_snoop_cd_responder #(
  parameter int AddrWidth       = 64,
  parameter int DcacheLineWidth = 128,
  parameter int AxiDataWidth    = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ac_valid_i,
  output logic                       ac_ready_o,
  input  logic [AddrWidth-1:0]       ac_addr_i,
  input  logic [3:0]                 ac_snoop_i,
  output logic                       cr_valid_o,
  input  logic                       cr_ready_i,
  output logic [4:0]                 cr_resp_o,
  output logic                       cd_valid_o,
  input  logic                       cd_ready_i,
  output logic [AxiDataWidth-1:0]    cd_data_o,
  output logic                       cd_last_o,
  output logic                       lk_req_o,
  output logic [AddrWidth-1:0]       lk_addr_o,
  input  logic                       lk_gnt_i,
  input  logic                       lk_rvalid_i,
  input  logic                       lk_hit_i,
  input  logic                       lk_dirty_i,
  input  logic                       lk_shared_i,
  input  logic [DcacheLineWidth-1:0] lk_line_i,
  output logic                       upd_valid_o,
  input  logic                       upd_ready_i,
  output logic                       upd_inval_o,
  output logic                       upd_clean_o,
  output logic                       upd_share_o
`ifdef ACE_SNOOP_PERF_CNT_EN
  ,
  output logic [31:0]                perf_hit_o,
  output logic [31:0]                perf_miss_o,
  output logic [31:0]                perf_beats_o
`endif
);

  localparam int DcacheLineWords = DcacheLineWidth / AxiDataWidth;
  localparam int CntW = (DcacheLineWords > 1) ? $clog2(DcacheLineWords) : 1;
  localparam int OffW = $clog2(DcacheLineWidth / 8);

  // cr_resp bit positions: {WasUnique,IsShared,PassDirty,Error,DataTransfer}
  localparam int RbDt  = 0;
  localparam int RbErr = 1;
  localparam int RbPd  = 2;
  localparam int RbIs  = 3;
  localparam int RbWu  = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WAIT, S_RESP, S_DATA, S_UPDATE
  } state_t;

  typedef struct packed {
    logic [4:0] resp;
    logic       upd;
    logic       inval;
    logic       clean;
    logic       share;
  } dec_t;

  function automatic dec_t snoop_decode(input logic [3:0] snoop, input logic hit,
                                        input logic dirty, input logic shared);
    dec_t d;
    d = '0;
    case (snoop)
      4'b0000: begin
        d.resp[RbDt] = hit;
        d.resp[RbIs] = hit;
      end
      4'b0001, 4'b0010, 4'b0011: begin
        d.resp[RbDt] = hit;
        d.resp[RbIs] = hit;
        d.resp[RbPd] = hit & dirty;
        d.upd        = hit;
        d.share      = 1'b1;
        d.clean      = dirty;
      end
      4'b0111: begin
        d.resp[RbDt] = hit;
        d.resp[RbPd] = hit & dirty;
        d.upd        = hit;
        d.inval      = 1'b1;
      end
      4'b1001: begin
        d.resp[RbDt] = hit & dirty;
        d.resp[RbPd] = hit & dirty;
        d.upd        = hit;
        d.inval      = 1'b1;
      end
      4'b1000: begin
        d.resp[RbDt] = hit & dirty;
        d.resp[RbPd] = hit & dirty;
        d.resp[RbIs] = hit;
        d.upd        = hit & dirty;
        d.clean      = dirty;
      end
      4'b1101: begin
        d.upd   = hit;
        d.inval = 1'b1;
      end
      default: d.resp[RbErr] = 1'b1;
    endcase
    // Unsupported types report only Error, even on a hit
    if (hit && !d.resp[RbErr]) d.resp[RbWu] = ~shared;
    return d;
  endfunction

  function automatic logic [AxiDataWidth-1:0] line_beat(input logic [DcacheLineWidth-1:0] line,
                                                        input int idx);
    return line[idx*AxiDataWidth +: AxiDataWidth];
  endfunction

  state_t                       r_state;
  logic                         r_ac_ready;
  logic                         r_lk_req;
  logic                         r_cr_valid;
  logic                         r_cd_valid;
  logic                         r_upd_valid;
  logic [4:0]                   r_cr_resp;
  logic                         r_cd_last;
  logic [AxiDataWidth-1:0]      r_cd_data;
  logic [CntW-1:0]              r_cnt;
  logic [AddrWidth-1:OffW]      r_addr;
  logic [3:0]                   r_snoop;
  logic [DcacheLineWidth-1:0]   r_line;
  logic                         r_upd_req;
  logic                         r_inval;
  logic                         r_clean;
  logic                         r_share;

  dec_t                         w_dec;
  logic [CntW-1:0]              w_cnt_nxt;
  logic                         w_unused;

  assign w_dec     = snoop_decode(r_snoop, lk_hit_i, lk_dirty_i, lk_shared_i);
  assign w_cnt_nxt = r_cnt + CntW'(1);
  assign w_unused  = ^ac_addr_i[OffW-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_ac_ready  <= 1'b1;
      r_lk_req    <= 1'b0;
      r_cr_valid  <= 1'b0;
      r_cd_valid  <= 1'b0;
      r_upd_valid <= 1'b0;
      r_cr_resp   <= '0;
      r_cd_last   <= 1'b0;
      r_cd_data   <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_snoop     <= '0;
      r_line      <= '0;
      r_upd_req   <= 1'b0;
      r_inval     <= 1'b0;
      r_clean     <= 1'b0;
      r_share     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (ac_valid_i) begin
          r_addr     <= ac_addr_i[AddrWidth-1:OffW];
          r_snoop    <= ac_snoop_i;
          r_ac_ready <= 1'b0;
          r_lk_req   <= 1'b1;
          r_state    <= S_LOOKUP;
        end
        S_LOOKUP: if (lk_gnt_i) begin
          r_lk_req <= 1'b0;
          r_state  <= S_WAIT;
        end
        S_WAIT: if (lk_rvalid_i) begin
          r_line     <= lk_line_i;
          r_cr_resp  <= w_dec.resp;
          r_upd_req  <= w_dec.upd;
          r_inval    <= w_dec.inval;
          r_clean    <= w_dec.clean;
          r_share    <= w_dec.share;
          r_cr_valid <= 1'b1;
          r_state    <= S_RESP;
        end
        S_RESP: if (cr_ready_i) begin
          r_cr_valid <= 1'b0;
          if (r_cr_resp[RbDt]) begin
            r_cd_valid <= 1'b1;
            r_cd_data  <= line_beat(r_line, 0);
            r_cd_last  <= (DcacheLineWords == 1);
            r_cnt      <= '0;
            r_state    <= S_DATA;
          end else if (r_upd_req) begin
            r_upd_valid <= 1'b1;
            r_state     <= S_UPDATE;
          end else begin
            r_ac_ready <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        // Next beat is preloaded on each handshake so cd_data_o comes straight from a flop
        S_DATA: if (cd_ready_i) begin
          if (r_cd_last) begin
            r_cd_valid <= 1'b0;
            r_cd_last  <= 1'b0;
            r_cnt      <= '0;
            if (r_upd_req) begin
              r_upd_valid <= 1'b1;
              r_state     <= S_UPDATE;
            end else begin
              r_ac_ready <= 1'b1;
              r_state    <= S_IDLE;
            end
          end else begin
            r_cnt     <= w_cnt_nxt;
            r_cd_data <= line_beat(r_line, int'(w_cnt_nxt));
            r_cd_last <= (w_cnt_nxt == CntW'(DcacheLineWords - 1));
          end
        end
        S_UPDATE: if (upd_ready_i) begin
          r_upd_valid <= 1'b0;
          r_ac_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_ac_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign ac_ready_o  = r_ac_ready;
  assign lk_req_o    = r_lk_req;
  assign lk_addr_o   = {r_addr, {OffW{1'b0}}};
  assign cr_valid_o  = r_cr_valid;
  assign cr_resp_o   = r_cr_resp;
  assign cd_valid_o  = r_cd_valid;
  assign cd_data_o   = r_cd_data;
  assign cd_last_o   = r_cd_last;
  assign upd_valid_o = r_upd_valid;
  assign upd_inval_o = r_inval;
  assign upd_clean_o = r_clean;
  assign upd_share_o = r_share;

`ifdef ACE_SNOOP_PERF_CNT_EN
  logic [31:0] r_perf_hit;
  logic [31:0] r_perf_miss;
  logic [31:0] r_perf_beats;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_hit   <= '0;
      r_perf_miss  <= '0;
      r_perf_beats <= '0;
    end else begin
      if (r_state == S_WAIT && lk_rvalid_i) begin
        if (lk_hit_i) r_perf_hit  <= r_perf_hit + 32'd1;
        else          r_perf_miss <= r_perf_miss + 32'd1;
      end
      if (r_cd_valid && cd_ready_i) r_perf_beats <= r_perf_beats + 32'd1;
    end
  end

  assign perf_hit_o   = r_perf_hit;
  assign perf_miss_o  = r_perf_miss;
  assign perf_beats_o = r_perf_beats;
`endif

endmodule

// File: tb/tb_ace_snoop_cd_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for ace_snoop_cd_responder: the bench plays AC master, dcache and CR/CD/update sinks.
module tb_ace_snoop_cd_responder;

  localparam int AW    = 64;
  localparam int LW    = 128;
  localparam int DW    = 64;
  localparam int WORDS = LW / DW;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          ac_valid = 1'b0, ac_ready;
  logic [AW-1:0] ac_addr = '0;
  logic [3:0]    ac_snoop = '0;
  logic          cr_valid, cr_ready = 1'b0;
  logic [4:0]    cr_resp;
  logic          cd_valid, cd_ready = 1'b0, cd_last;
  logic [DW-1:0] cd_data;
  logic          lk_req, lk_gnt = 1'b0, lk_rvalid = 1'b0;
  logic [AW-1:0] lk_addr;
  logic          lk_hit = 1'b0, lk_dirty = 1'b0, lk_shared = 1'b0;
  logic [LW-1:0] lk_line = '0;
  logic          upd_valid, upd_ready = 1'b0, upd_inval, upd_clean, upd_share;
`ifdef ACE_SNOOP_PERF_CNT_EN
  logic [31:0]   perf_hit, perf_miss, perf_beats;
`endif

  always #5 clk = ~clk;

  ace_snoop_cd_responder #(.AddrWidth(AW), .DcacheLineWidth(LW), .AxiDataWidth(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ac_valid_i(ac_valid), .ac_ready_o(ac_ready), .ac_addr_i(ac_addr), .ac_snoop_i(ac_snoop),
    .cr_valid_o(cr_valid), .cr_ready_i(cr_ready), .cr_resp_o(cr_resp),
    .cd_valid_o(cd_valid), .cd_ready_i(cd_ready), .cd_data_o(cd_data), .cd_last_o(cd_last),
    .lk_req_o(lk_req), .lk_addr_o(lk_addr), .lk_gnt_i(lk_gnt), .lk_rvalid_i(lk_rvalid),
    .lk_hit_i(lk_hit), .lk_dirty_i(lk_dirty), .lk_shared_i(lk_shared), .lk_line_i(lk_line),
    .upd_valid_o(upd_valid), .upd_ready_i(upd_ready), .upd_inval_o(upd_inval),
    .upd_clean_o(upd_clean), .upd_share_o(upd_share)
`ifdef ACE_SNOOP_PERF_CNT_EN
    , .perf_hit_o(perf_hit), .perf_miss_o(perf_miss), .perf_beats_o(perf_beats)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [4:0]  exp_cr[$];
  logic [DW:0] exp_cd[$];
  logic [2:0]  exp_upd[$];
  int rdy_mode = 0;
  bit tog = 1'b0;
  int m_hits = 0, m_miss = 0, m_beats = 0;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endfunction

  // Reference: response bits and update flags straight from the snoop response table.
  function automatic void ref_model(input logic [3:0] sn, input bit hit, input bit dirty,
                                    input bit shared, output logic [4:0] resp,
                                    output bit upd, output logic [2:0] flags);
    bit wu, is, pd, err, dt, inval, clean, share;
    {wu, is, pd, err, dt, inval, clean, share} = '0;
    upd = 1'b0;
    if (!(sn inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13})) err = 1'b1;
    else if (hit) begin
      wu = !shared;
      if (sn == 4'd0) begin dt = 1; is = 1; end
      if (sn inside {4'd1, 4'd2, 4'd3}) begin
        dt = 1; is = 1; pd = dirty; upd = 1; share = 1; clean = dirty;
      end
      if (sn == 4'd7) begin dt = 1; pd = dirty; upd = 1; inval = 1; end
      if (sn == 4'd9) begin dt = dirty; pd = dirty; upd = 1; inval = 1; end
      if (sn == 4'd8) begin dt = dirty; pd = dirty; is = 1; upd = dirty; clean = dirty; end
      if (sn == 4'd13) begin upd = 1; inval = 1; end
    end
    resp  = {wu, is, pd, err, dt};
    flags = {inval, clean, share};
  endfunction

  // Sink readiness patterns
  always @(posedge clk) begin
    #1;
    tog = ~tog;
    case (rdy_mode)
      0:       begin cr_ready = 1; cd_ready = 1;   upd_ready = 1; end
      1: begin
        cr_ready  = ($urandom_range(0, 3) != 0);
        cd_ready  = ($urandom_range(0, 3) != 0);
        upd_ready = ($urandom_range(0, 3) != 0);
      end
      2:       begin cr_ready = 1; cd_ready = tog; upd_ready = 1; end
      default: begin cr_ready = 1; cd_ready = 0;   upd_ready = 1; end
    endcase
  end

  // Monitor: pops the scoreboard on every handshake and checks payload stability under stall
  logic          p_cr_v = 0, p_cd_v = 0, p_upd_v = 0;
  logic [4:0]    p_cr_resp;
  logic [DW:0]   p_cd;
  logic [2:0]    p_upd;
  always @(negedge clk) begin
    if (rst_i) begin
      p_cr_v = 0; p_cd_v = 0; p_upd_v = 0;
    end else begin
      if (p_cr_v) begin
        chk("cr_hold_valid", 128'(cr_valid), 128'(1));
        chk("cr_hold_resp", 128'(cr_resp), 128'(p_cr_resp));
      end
      if (p_cd_v) begin
        chk("cd_hold_valid", 128'(cd_valid), 128'(1));
        chk("cd_hold_data", 128'({cd_last, cd_data}), 128'(p_cd));
      end
      if (p_upd_v) begin
        chk("upd_hold_valid", 128'(upd_valid), 128'(1));
        chk("upd_hold_flags", 128'({upd_inval, upd_clean, upd_share}), 128'(p_upd));
      end
      if (cr_valid && cr_ready) begin
        if (exp_cr.size() == 0) chk("cr_spurious", 128'(cr_valid), 128'(0));
        else chk("cr_resp", 128'(cr_resp), 128'(exp_cr.pop_front()));
      end
      if (cd_valid && cd_ready) begin
        if (exp_cd.size() == 0) chk("cd_spurious", 128'(cd_valid), 128'(0));
        else chk("cd_beat", 128'({cd_last, cd_data}), 128'(exp_cd.pop_front()));
      end
      if (upd_valid && upd_ready) begin
        if (exp_upd.size() == 0) chk("upd_spurious", 128'(upd_valid), 128'(0));
        else chk("upd_flags", 128'({upd_inval, upd_clean, upd_share}), 128'(exp_upd.pop_front()));
      end
      p_cr_v  = cr_valid && !cr_ready;   p_cr_resp = cr_resp;
      p_cd_v  = cd_valid && !cd_ready;   p_cd      = {cd_last, cd_data};
      p_upd_v = upd_valid && !upd_ready; p_upd     = {upd_inval, upd_clean, upd_share};
    end
  end

  // Issue one snoop and act as the dcache for it; called and returns at posedge+1.
  task automatic run_snoop(input logic [3:0] sn, input bit hit, input bit dirty, input bit shared,
                           input logic [LW-1:0] line, input int gnt_dly, input int rv_dly);
    logic [AW-1:0] addr;
    logic [4:0]    r;
    bit            u;
    logic [2:0]    f;
    int            n;
    n = 0;
    while (!ac_ready && n < 400) begin @(posedge clk); #1; n++; end
    chk("ac_ready_wait", 128'(ac_ready), 128'(1));
    if (!ac_ready) return;
    addr = {$urandom, $urandom};
    ref_model(sn, hit, dirty, shared, r, u, f);
    exp_cr.push_back(r);
    if (r[0]) for (int i = 0; i < WORDS; i++) exp_cd.push_back({i == WORDS - 1, line[i*DW +: DW]});
    if (u) exp_upd.push_back(f);
    if (hit) m_hits++; else m_miss++;
    if (r[0]) m_beats += WORDS;
    ac_valid = 1; ac_addr = addr; ac_snoop = sn;
    @(posedge clk); #1;
    ac_valid = 0; ac_addr = {$urandom, $urandom};
    repeat (gnt_dly) begin @(posedge clk); #1; end
    chk("lk_req", 128'(lk_req), 128'(1));
    chk("lk_addr", 128'(lk_addr), 128'({addr[AW-1:4], 4'b0000}));
    lk_gnt = 1;
    @(posedge clk); #1;
    lk_gnt = 0;
    chk("lk_req_drop", 128'(lk_req), 128'(0));
    repeat (rv_dly) begin @(posedge clk); #1; end
    lk_rvalid = 1; lk_hit = hit; lk_dirty = dirty; lk_shared = shared; lk_line = line;
    @(posedge clk); #1;
    lk_rvalid = 0; lk_line = {4{$urandom}}; lk_hit = $urandom; lk_dirty = $urandom;
    chk("cr_after_rvalid", 128'(cr_valid), 128'(1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(ac_ready && exp_cr.size() == 0 && exp_cd.size() == 0 && exp_upd.size() == 0)
           && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_idle", 128'(ac_ready), 128'(1));
    chk("drain_queues", 128'(exp_cr.size() + exp_cd.size() + exp_upd.size()), 128'(0));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ac_ready"}, 128'(ac_ready), 128'(1));
    chk({tag, "_valids"}, 128'({cr_valid, cd_valid, upd_valid, lk_req}), 128'(0));
    chk({tag, "_cr_resp"}, 128'(cr_resp), 128'(0));
    chk({tag, "_cd_last_data"}, 128'({cd_last, cd_data}), 128'(0));
    chk({tag, "_lk_addr"}, 128'(lk_addr), 128'(0));
    chk({tag, "_upd_flags"}, 128'({upd_inval, upd_clean, upd_share}), 128'(0));
`ifdef ACE_SNOOP_PERF_CNT_EN
    chk({tag, "_perf"}, 128'({perf_hit, perf_miss, perf_beats}), 128'(0));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] ab_line;
    logic [3:0]    sn_tab[11];
    int            n;
`ifdef ACE_SNOOP_PERF_CNT_EN
    logic [31:0]   h0, m0, b0;
`endif
    ab_line = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB};
    sn_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd9, 4'd8, 4'd13, 4'd5, 4'd4, 4'd15};

    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    check_reset_state("por");

    // ReadShared hit dirty shared, minimum latency
    rdy_mode = 0;
    run_snoop(4'b0001, 1, 1, 1, ab_line, 0, 0);
    wait_drain();

    // ReadUnique hit clean unique with toggling cd_ready
    rdy_mode = 2;
    run_snoop(4'b0111, 1, 0, 0, {4{$urandom}}, 1, 2);
    wait_drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // CleanInvalid miss: ready for the next snoop right after the CR handshake
    run_snoop(4'b1001, 0, 1, 0, {4{$urandom}}, 0, 0);
    @(posedge clk); #1;
    chk("miss_ac_ready_after_cr", 128'(ac_ready), 128'(1));
    chk("miss_no_valids", 128'({cr_valid, cd_valid, upd_valid}), 128'(0));

    // Unsupported encoding on a hit
    run_snoop(4'b0101, 1, 1, 0, {4{$urandom}}, 0, 1);
    wait_drain();

`ifdef ACE_SNOOP_PERF_CNT_EN
    h0 = perf_hit; m0 = perf_miss; b0 = perf_beats;
`endif
    for (int i = 0; i < 3; i++) run_snoop(4'b0000, 1, i[0], i[1], {4{$urandom}}, 0, 0);
    run_snoop(4'b0000, 0, 0, 0, {4{$urandom}}, 0, 0);
    wait_drain();
`ifdef ACE_SNOOP_PERF_CNT_EN
    chk("perf_hit_delta", 128'(perf_hit - h0), 128'(3));
    chk("perf_miss_delta", 128'(perf_miss - m0), 128'(1));
    chk("perf_beats_delta", 128'(perf_beats - b0), 128'(6));
`endif

    // Reset in the middle of the CD stream
    rdy_mode = 3;
    run_snoop(4'b0001, 1, 1, 0, {4{$urandom}}, 0, 0);
    n = 0;
    while (!cd_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("cd_valid_before_reset", 128'(cd_valid), 128'(1));
    rst_i = 1;
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    exp_cr.delete(); exp_cd.delete(); exp_upd.delete();
    m_hits = 0; m_miss = 0; m_beats = 0;
    check_reset_state("mid_reset");
    rdy_mode = 0;
    run_snoop(4'b0010, 1, 0, 1, {4{$urandom}}, 0, 0);
    wait_drain();

    // Randomized traffic
    rdy_mode = 1;
    for (int i = 0; i < 80; i++) begin
      run_snoop(sn_tab[$urandom_range(0, 10)], $urandom_range(0, 3) != 0, 1'($urandom),
                1'($urandom), {4{$urandom}}, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    rdy_mode = 0;
    wait_drain();
`ifdef ACE_SNOOP_PERF_CNT_EN
    chk("perf_hit_total", 128'(perf_hit), 128'(m_hits));
    chk("perf_miss_total", 128'(perf_miss), 128'(m_miss));
    chk("perf_beats_total", 128'(perf_beats), 128'(m_beats));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ace_snoop_cd_responder.md
Name: ace_snoop_cd_responder

Overview:
- Cache-side end of the ACE snoop channels; the transmitter of the CR/CD streams that the CCU control memory unit consumes.
- Accepts one AC snoop at a time and looks up the line in the local dcache through a lookup/update port.
- Returns a CR response, then streams the cache line over CD as DcacheLineWords beats.
- Updates the line state afterwards. Sits between the dcache controller and the CCU snoop port of one core.

Parameters:
AddrWidth, 64, width of AC address and cache lookup address
DcacheLineWidth, 128, cache line width in bits
AxiDataWidth, 64, CD beat width; DcacheLineWords = DcacheLineWidth/AxiDataWidth (localparam, must be >=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous and active-high
ac_valid_i  in  1  snoop request valid
ac_ready_o  out  1  snoop request accepted
ac_addr_i  in  AddrWidth  snoop address
ac_snoop_i  in  4  ACE snoop type
cr_valid_o  out  1  snoop response valid
cr_ready_i  in  1  snoop response accepted
cr_resp_o  out  5  {WasUnique,IsShared,PassDirty,Error,DataTransfer}
cd_valid_o  out  1  snoop data valid
cd_ready_i  in  1  snoop data accepted
cd_data_o  out  AxiDataWidth  snoop data beat
cd_last_o  out  1  final beat of line
lk_req_o  out  1  cache lookup request
lk_addr_o  out  AddrWidth  lookup address, line aligned (low log2(DcacheLineWidth/8) bits zero)
lk_gnt_i  in  1  lookup accepted
lk_rvalid_i  in  1  lookup result valid; arrives one or more cycles after grant
lk_hit_i  in  1  line present
lk_dirty_i  in  1  line dirty
lk_shared_i  in  1  line shared
lk_line_i  in  DcacheLineWidth  line data
upd_valid_o  out  1  state update request
upd_ready_i  in  1  state update accepted
upd_inval_o  out  1  invalidate line
upd_clean_o  out  1  clear dirty bit
upd_share_o  out  1  set shared bit

Behaviour:
- Reset (rst_i high at a clock edge): FSM to IDLE.
  - All valid/req outputs 0; cr_resp_o 0, cd_last_o 0, cd_data_o 0.
  - Beat counter 0; captured registers 0.
  - Reset mid-transaction abandons it; no partial CD is completed.
- FSM states and transitions:
  - IDLE: ac_ready_o=1. On ac_valid_i, capture addr and snoop type; go to LOOKUP.
  - LOOKUP: lk_req_o=1 with lk_addr_o held until lk_gnt_i; then go to WAIT.
  - WAIT: on lk_rvalid_i, capture hit/dirty/shared/line and compute cr_resp; go to RESP.
  - RESP: cr_valid_o=1, cr_resp_o stable until cr_ready_i.
    - On handshake with DataTransfer=1, go to DATA.
    - Otherwise go to UPDATE if an update is required, else IDLE.
  - DATA: cd_valid_o=1; cd_data_o = line[cnt*AxiDataWidth +: AxiDataWidth]; cd_last_o = (cnt == DcacheLineWords-1).
    - cnt increments on each cd handshake.
    - On the last handshake, cnt clears to 0; go to UPDATE if required, else IDLE.
  - UPDATE: upd_valid_o=1 with flags stable until upd_ready_i; then go to IDLE.
- Minimum latency AC accept to CR valid: 3 cycles (grant in same cycle, rvalid the next cycle).
- Payloads never change while valid=1 and ready=0.
- Response table. On a miss, cr_resp=0 with no data and no update, except an unsupported type, which always gives Error=1. WasUnique = hit & !shared on all hits.
  - ReadOnce (0000): DT=1, IS=1, PD=0; no update.
  - ReadShared/ReadClean/ReadNotSharedDirty (0001/0010/0011): DT=1, IS=1, PD=dirty; update share=1, clean=dirty.
  - ReadUnique (0111): DT=1, IS=0, PD=dirty; update inval=1.
  - CleanInvalid (1001): DT=dirty, PD=dirty, IS=0; update inval=1.
  - CleanShared (1000): DT=dirty, PD=dirty, IS=1; update clean=dirty, and only if dirty.
  - MakeInvalid (1101): DT=0, PD=0, IS=0; update inval=1.
  - Any other encoding: Error=1, all other bits 0; no data, no update.
- ac_ready_o is 0 outside IDLE, so back-to-back snoops are serialised with one IDLE cycle between them.
- DcacheLineWords=1: single beat with cd_last_o=1.

Optional Feature:
- Macro ACE_SNOOP_PERF_CNT_EN.
- When defined, add outputs perf_hit_o, perf_miss_o and perf_beats_o, each 32 bits.
  - perf_hit_o and perf_miss_o increment on lk_rvalid_i per lookup.
  - perf_beats_o increments per CD handshake.
  - All three wrap at 2^32 and reset to 0.
- When undefined, the ports and counters are absent and the logic is identical otherwise.

Test Plan:
- Reset: assert rst_i for 2 cycles mid-DATA -> next cycle all valids 0, ac_ready_o=1, cnt=0.
- ReadShared hit dirty, DcacheLineWidth=128, AxiDataWidth=64, line=0xAAAA_..._BBBB, cr_ready/cd_ready always 1 -> cr_resp=5'b01101 (WasUnique=0, IS=1, PD=1, Error=0, DT=1); CD beats 0xBBBB.. then 0xAAAA.. with last on beat 2; then upd share=1, clean=1.
- ReadUnique hit clean unique with cd_ready toggled 1-0-1 -> cr_resp=5'b10001; cd_data held during stall; exactly 2 beats; upd inval=1.
- Miss on CleanInvalid -> cr_resp=0; no cd_valid, no upd_valid; ac_ready_o=1 on the cycle after the CR handshake.
- Snoop 0101 -> cr_resp=5'b00010; no CD, no update.
- With ACE_SNOOP_PERF_CNT_EN: 3 hits of ReadOnce plus 1 miss -> perf_hit_o=3, perf_miss_o=1, perf_beats_o=6.
